serial_addsub_ctrl: RTL

Bit-serial add/subtract sequencer built around a single shared FULL_ADDER cell. It captures two WIDTH-bit operands on a START handshake and feeds the cell one bit per clock, LSB first, holding the carry in a flip-flop. It shifts the sum bits into a result register and reports carry-out and signed overflow. It serves as the area-minimal arithmetic unit next to the ALU, for slow-path add/sub operations.

---
 rtl/serial_addsub_ctrl_pkg.sv | 13 +
 rtl/serial_addsub_ctrl_full_adder.sv | 14 +
 rtl/serial_addsub_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer: the default
// datapath width and the sequencer state encodings.
package serial_addsub_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SAS_IDLE = 2'b00,
        SAS_RUN  = 2'b01,
        SAS_FIN  = 2'b10
    } sas_state_t;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational; the only arithmetic
// element of the serial sequencer.
module serial_addsub_ctrl_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder processes the
// operands LSB first over WIDTH cycles, yielding result, carry-out and overflow.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic             CO,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    sas_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             cmsb;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    serial_addsub_ctrl_full_adder u_full_adder (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= SAS_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cmsb   <= 1'b0;
            cnt    <= '0;
            RESULT <= '0;
            CO     <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            case (state)
                SAS_IDLE: begin
                    if (START) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry with OP.
                        a_sh   <= A;
                        b_sh   <= B ^ {WIDTH{OP}};
                        carry  <= OP;
                        cnt    <= '0;
                        RESULT <= '0;
                        CO     <= 1'b0;
                        OVF    <= 1'b0;
                        state  <= SAS_RUN;
                    end
                end
                SAS_RUN: begin
                    RESULT <= {fa_s, RESULT[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 2)) begin
                        cmsb <= fa_co;
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        CO    <= fa_co;
                        OVF   <= cmsb ^ fa_co;
                        state <= SAS_FIN;
                    end
                end
                SAS_FIN: begin
                    state <= SAS_IDLE;
                end
                default: begin
                    state <= SAS_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == SAS_RUN);
    assign DONE = (state == SAS_FIN);

endmodule
